// File: rtl/riscv_fault_monitor.sv
// First-fault classifier for riscv_top status: sticky cause bits, a timestamp against a
// saturating cycle counter, and a halt request that stays up until it is acknowledged.
module riscv_fault_monitor #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned INVALID_LIMIT = 4,
  parameter int unsigned BOOT_GRACE    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             opcode_valid,
  input  logic             error_instrmem_invalid_address,
  input  logic             error_instrmem_misaligned_access,
  input  logic             error_datamem_invalid_address,
  input  logic             error_datamem_misaligned_access,
  input  logic             clear,
  output logic             halt_req,
  output logic             fault_active,
  output logic [2:0]       fault_code,
  output logic [4:0]       sticky_errors,
  output logic [CNT_W-1:0] fault_cycle,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned IW         = $clog2(INVALID_LIMIT + 1);
  localparam int unsigned GRACE_LAST = (BOOT_GRACE > 0) ? BOOT_GRACE - 1 : 0;
  localparam int unsigned GW         = (GRACE_LAST > 0) ? $clog2(GRACE_LAST + 1) : 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;
  localparam state_e RESET_STATE = (BOOT_GRACE == 0) ? ST_RUN : ST_BOOT;

  state_e           state_q;
  logic [GW-1:0]    grace_q;
  logic [IW-1:0]    inv_q;
  logic [IW-1:0]    inv_d;
  logic             halt_q;
  logic [2:0]       code_q;
  logic [2:0]       code_d;
  logic [4:0]       sticky_q;
  logic [CNT_W-1:0] fcycle_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       mem_err;
  logic             inv_hit;
  logic [4:0]       causes;

  // Bit k-1 of the cause vector is fault code k, so it maps straight onto sticky_errors.
  always_comb begin
    mem_err = {error_datamem_misaligned_access, error_datamem_invalid_address,
               error_instrmem_misaligned_access, error_instrmem_invalid_address};
    inv_d   = '0;
    if (!opcode_valid) begin
      inv_d = (inv_q == IW'(INVALID_LIMIT)) ? inv_q : inv_q + IW'(1);
    end
    inv_hit = (state_q == ST_RUN) && !opcode_valid && (inv_d == IW'(INVALID_LIMIT));
    causes  = {inv_hit, mem_err};
    code_d  = 3'd0;
    if (causes[0])      code_d = 3'd1;
    else if (causes[1]) code_d = 3'd2;
    else if (causes[2]) code_d = 3'd3;
    else if (causes[3]) code_d = 3'd4;
    else if (causes[4]) code_d = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= RESET_STATE;
      grace_q  <= '0;
      inv_q    <= '0;
      halt_q   <= 1'b0;
      code_q   <= '0;
      sticky_q <= '0;
      fcycle_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // An acknowledge masks every input sampled in the same cycle.
      if (clear) begin
        sticky_q <= '0;
        if (state_q == ST_HALT) begin
          state_q  <= ST_RUN;
          halt_q   <= 1'b0;
          code_q   <= '0;
          fcycle_q <= '0;
          inv_q    <= '0;
        end
      end else begin
        sticky_q <= sticky_q | causes;
        case (state_q)
          ST_BOOT: begin
            if (|causes) begin
              state_q  <= ST_HALT;
              halt_q   <= 1'b1;
              code_q   <= code_d;
              fcycle_q <= cnt_q;
            end else if (grace_q == GW'(GRACE_LAST)) begin
              state_q <= ST_RUN;
            end else begin
              grace_q <= grace_q + GW'(1);
            end
          end
          ST_RUN: begin
            inv_q <= inv_d;
            if (|causes) begin
              state_q  <= ST_HALT;
              halt_q   <= 1'b1;
              code_q   <= code_d;
              fcycle_q <= cnt_q;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign halt_req      = halt_q;
  assign fault_active  = halt_q;
  assign fault_code    = code_q;
  assign sticky_errors = sticky_q;
  assign fault_cycle   = fcycle_q;
  assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_riscv_fault_monitor.sv
// Directed checks of riscv_fault_monitor: default configuration plus a narrow-counter,
// no-grace, single-low-limit configuration.
module tb_riscv_fault_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, op, im_inv, im_mis, dm_inv, dm_mis, clr;
  logic        halt, fact;
  logic [2:0]  code;
  logic [4:0]  sticky;
  logic [31:0] fcyc, cnt;

  logic        rstn2, op2, clr2;
  logic        halt2, fact2;
  logic [2:0]  code2;
  logic [4:0]  sticky2;
  logic [3:0]  fcyc2, cnt2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  riscv_fault_monitor #(.CNT_W(32), .INVALID_LIMIT(4), .BOOT_GRACE(2)) dut (
    .clk                              (clk),
    .rstn                             (rstn),
    .opcode_valid                     (op),
    .error_instrmem_invalid_address   (im_inv),
    .error_instrmem_misaligned_access (im_mis),
    .error_datamem_invalid_address    (dm_inv),
    .error_datamem_misaligned_access  (dm_mis),
    .clear                            (clr),
    .halt_req                         (halt),
    .fault_active                     (fact),
    .fault_code                       (code),
    .sticky_errors                    (sticky),
    .fault_cycle                      (fcyc),
    .cycle_count                      (cnt)
  );

  riscv_fault_monitor #(.CNT_W(4), .INVALID_LIMIT(1), .BOOT_GRACE(0)) dut2 (
    .clk                              (clk),
    .rstn                             (rstn2),
    .opcode_valid                     (op2),
    .error_instrmem_invalid_address   (1'b0),
    .error_instrmem_misaligned_access (1'b0),
    .error_datamem_invalid_address    (1'b0),
    .error_datamem_misaligned_access  (1'b0),
    .clear                            (clr2),
    .halt_req                         (halt2),
    .fault_active                     (fact2),
    .fault_code                       (code2),
    .sticky_errors                    (sticky2),
    .fault_cycle                      (fcyc2),
    .cycle_count                      (cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status1(input string tag, input logic exp_halt, input logic [2:0] exp_code,
                         input logic [4:0] exp_sticky, input logic [31:0] exp_fcyc,
                         input logic [31:0] exp_cnt);
    check({tag, ".halt"},   32'(halt),   32'(exp_halt));
    check({tag, ".active"}, 32'(fact),   32'(exp_halt));
    check({tag, ".code"},   32'(code),   32'(exp_code));
    check({tag, ".sticky"}, 32'(sticky), 32'(exp_sticky));
    check({tag, ".fcycle"}, fcyc,        exp_fcyc);
    check({tag, ".cnt"},    cnt,         exp_cnt);
  endtask

  task automatic status2(input string tag, input logic exp_halt, input logic [2:0] exp_code,
                         input logic [4:0] exp_sticky, input logic [3:0] exp_fcyc,
                         input logic [3:0] exp_cnt);
    check({tag, ".halt"},   32'(halt2),   32'(exp_halt));
    check({tag, ".active"}, 32'(fact2),   32'(exp_halt));
    check({tag, ".code"},   32'(code2),   32'(exp_code));
    check({tag, ".sticky"}, 32'(sticky2), 32'(exp_sticky));
    check({tag, ".fcycle"}, 32'(fcyc2),   32'(exp_fcyc));
    check({tag, ".cnt"},    32'(cnt2),    32'(exp_cnt));
  endtask

  initial begin
    rstn = 1'b0; op = 1'b0; im_inv = 1'b0; im_mis = 1'b0; dm_inv = 1'b0; dm_mis = 1'b0;
    clr = 1'b0; rstn2 = 1'b0; op2 = 1'b1; clr2 = 1'b0;
    tick();
    tick();
    status1("reset", 1'b0, 3'd0, 5'b00000, 32'd0, 32'd0);

    // Cycles 0,1 are grace; lows in cycles 2..5 fault at the edge of cycle 5.
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    status1("grace_no_fault", 1'b0, 3'd0, 5'b00000, 32'd0, 32'd4);
    tick();
    check("pre_limit.halt", 32'(halt), 32'd0);
    tick();
    status1("invalid_op", 1'b1, 3'd5, 5'b10000, 32'd5, 32'd6);

    clr = 1'b1; op = 1'b1;
    tick();
    clr = 1'b0;
    status1("clear", 1'b0, 3'd0, 5'b00000, 32'd0, 32'd7);

    for (int i = 0; i < 3; i++) tick();
    dm_mis = 1'b1; im_inv = 1'b1;
    tick();
    dm_mis = 1'b0; im_inv = 1'b0;
    status1("priority_1_over_4", 1'b1, 3'd1, 5'b01001, 32'd10, 32'd11);
    tick();
    dm_inv = 1'b1;
    tick();
    dm_inv = 1'b0;
    status1("halt_accumulate", 1'b1, 3'd1, 5'b01101, 32'd10, 32'd13);

    im_mis = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    status1("clear_wins", 1'b0, 3'd0, 5'b00000, 32'd0, 32'd14);
    tick();
    im_mis = 1'b0;
    status1("refault", 1'b1, 3'd2, 5'b00010, 32'd14, 32'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clear2.halt", 32'(halt), 32'd0);

    // Run of three lows broken by a high, then three more lows: no fault yet.
    for (int i = 0; i < 7; i++) begin
      op = (i == 3);
      tick();
    end
    op = 1'b0;
    check("broken_run.halt", 32'(halt), 32'd0);
    tick();
    status1("fourth_low", 1'b1, 3'd5, 5'b10000, 32'd23, 32'd24);

    clr = 1'b1; op = 1'b1;
    tick();
    clr = 1'b0; op = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    dm_mis = 1'b1;
    tick();
    dm_mis = 1'b0;
    status1("mem_beats_opcode", 1'b1, 3'd4, 5'b11000, 32'd28, 32'd29);

    rstn = 1'b0;
    tick();
    status1("reset_in_halt", 1'b0, 3'd0, 5'b00000, 32'd0, 32'd0);
    rstn = 1'b1;
    tick();
    check("boot_ignores_op.halt", 32'(halt), 32'd0);
    dm_inv = 1'b1;
    tick();
    dm_inv = 1'b0;
    status1("boot_mem_fault", 1'b1, 3'd3, 5'b00100, 32'd1, 32'd2);

    // Narrow counter, no boot grace, single-low limit.
    status2("r2_reset", 1'b0, 3'd0, 5'b00000, 4'd0, 4'd0);
    rstn2 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    status2("r2_saturate", 1'b0, 3'd0, 5'b00000, 4'd0, 4'd15);
    op2 = 1'b0;
    tick();
    status2("r2_fault_at_sat", 1'b1, 3'd5, 5'b10000, 4'd15, 4'd15);
    rstn2 = 1'b0;
    tick();
    status2("r2_reset_in_halt", 1'b0, 3'd0, 5'b00000, 4'd0, 4'd0);
    rstn2 = 1'b1;
    tick();
    status2("r2_starts_in_run", 1'b1, 3'd5, 5'b10000, 4'd0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
